// File: rtl/wb_stage_buf_pkg.sv
`default_nettype none
// ============================================================================
// wb_stage_buf_pkg : shared register-file widths for the writeback buffer
// Revision : 1.0
// ============================================================================
package wb_stage_buf_pkg;

  localparam int c_reg_bus_w  = 32;
  localparam int c_reg_addr_w = 5;

endpackage
`default_nettype wire

// File: rtl/wb_fwd_match.sv
`default_nettype none
// ============================================================================
// wb_fwd_match : priority search of buffered writes for a forwarding address
// Revision : 1.0
// ============================================================================
module wb_fwd_match
  import wb_stage_buf_pkg::*;
#(
  parameter int DATA_W = c_reg_bus_w,
  parameter int ADDR_W = c_reg_addr_w,
  parameter int NPORT  = 2,
  parameter int DEPTH  = 2
) (
  input  logic [DEPTH-1:0]              ent_valid,
  input  logic [DEPTH*NPORT-1:0]        ent_we,
  input  logic [DEPTH*NPORT*ADDR_W-1:0] ent_waddr,
  input  logic [DEPTH*NPORT*DATA_W-1:0] ent_wdata,
  input  logic [ADDR_W-1:0]             raddr,
  output logic                          hit,
  output logic [DATA_W-1:0]             data
);

  // Entries arrive oldest first; scanning upward lets the youngest entry and
  // the highest port overwrite any earlier match.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int p = 0; p < NPORT; p++) begin
        if (ent_valid[e] && ent_we[e*NPORT + p] &&
            (ent_waddr[(e*NPORT + p)*ADDR_W +: ADDR_W] == raddr)) begin
          hit  = 1'b1;
          data = ent_wdata[(e*NPORT + p)*DATA_W +: DATA_W];
        end
      end
    end
    if (raddr == '0) begin
      hit  = 1'b0;
      data = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage_buf.sv
`default_nettype none
// ============================================================================
// wb_stage_buf : circular writeback staging FIFO with register forwarding
// Revision : 1.0
// ============================================================================
module wb_stage_buf
  import wb_stage_buf_pkg::*;
#(
  parameter int DATA_W = c_reg_bus_w,
  parameter int ADDR_W = c_reg_addr_w,
  parameter int NPORT  = 2,
  parameter int DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NPORT-1:0]          in_we,
  input  logic [NPORT*ADDR_W-1:0]   in_waddr,
  input  logic [NPORT*DATA_W-1:0]   in_wdata,
  input  logic                      stall_i,
  input  logic                      flush_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NPORT-1:0]          out_we,
  output logic [NPORT*ADDR_W-1:0]   out_waddr,
  output logic [NPORT*DATA_W-1:0]   out_wdata,
  input  logic [ADDR_W-1:0]         fwd_raddr,
  output logic                      fwd_hit,
  output logic [DATA_W-1:0]         fwd_data,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int                 c_ptr_w = $clog2(DEPTH);
  localparam int                 c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  logic [c_ptr_w-1:0]        r_rd_ptr;
  logic [c_ptr_w-1:0]        r_wr_ptr;
  logic [c_cnt_w-1:0]        r_count;
  logic [NPORT-1:0]          r_we    [DEPTH];
  logic [NPORT*ADDR_W-1:0]   r_waddr [DEPTH];
  logic [NPORT*DATA_W-1:0]   r_wdata [DEPTH];

  logic                      w_push;
  logic                      w_pop;
  logic [NPORT-1:0]          w_we_masked;

  logic [DEPTH-1:0]              w_age_valid;
  logic [DEPTH*NPORT-1:0]        w_age_we;
  logic [DEPTH*NPORT*ADDR_W-1:0] w_age_waddr;
  logic [DEPTH*NPORT*DATA_W-1:0] w_age_wdata;
  logic                          w_fwd_hit;
  logic [DATA_W-1:0]             w_fwd_data;

  // Acceptance looks only at occupancy, so a full buffer refuses even when popping.
  assign in_ready  = rst && (r_count < c_depth) && !stall_i && !flush_i;
  assign out_valid = rst && (r_count != '0) && !stall_i;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  for (genvar k = 0; k < NPORT; k++) begin : g_mask
    assign w_we_masked[k] = in_we[k] && (in_waddr[k*ADDR_W +: ADDR_W] != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_we[i] <= '0;
      end
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_we[r_wr_ptr] <= w_we_masked;
        r_wr_ptr       <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_w'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_waddr[r_wr_ptr] <= in_waddr;
      r_wdata[r_wr_ptr] <= in_wdata;
    end
  end

  assign out_we    = out_valid ? r_we[r_rd_ptr]    : '0;
  assign out_waddr = out_valid ? r_waddr[r_rd_ptr] : '0;
  assign out_wdata = out_valid ? r_wdata[r_rd_ptr] : '0;
  assign count_o   = r_count;

  // Re-order storage by age (slot 0 = head) so the matcher sees oldest first.
  for (genvar i = 0; i < DEPTH; i++) begin : g_age
    logic [c_ptr_w-1:0] w_slot;
    assign w_slot                                       = r_rd_ptr + c_ptr_w'(i);
    assign w_age_valid[i]                               = c_cnt_w'(i) < r_count;
    assign w_age_we[i*NPORT +: NPORT]                   = r_we[w_slot];
    assign w_age_waddr[i*NPORT*ADDR_W +: NPORT*ADDR_W]  = r_waddr[w_slot];
    assign w_age_wdata[i*NPORT*DATA_W +: NPORT*DATA_W]  = r_wdata[w_slot];
  end

  wb_fwd_match #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NPORT  (NPORT),
    .DEPTH  (DEPTH)
  ) u_fwd_match (
    .ent_valid (w_age_valid),
    .ent_we    (w_age_we),
    .ent_waddr (w_age_waddr),
    .ent_wdata (w_age_wdata),
    .raddr     (fwd_raddr),
    .hit       (w_fwd_hit),
    .data      (w_fwd_data)
  );

  assign fwd_hit  = rst && w_fwd_hit;
  assign fwd_data = fwd_hit ? w_fwd_data : '0;

endmodule
`default_nettype wire

// File: doc/wb_stage_buf.md
WB_STAGE_BUF -- requirements
Module: wb_stage_buf

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the register address width.
REQ-003 The block SHALL have parameter NPORT, default 2, meaning the number of write ports carried per entry.
REQ-004 The block SHALL have parameter DEPTH, default 2, meaning the buffer entry count, a power of two, at least 2.
REQ-005 The block SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 The block SHALL have port in_valid  input  1  upstream entry valid.
REQ-008 The block SHALL have port in_ready  output  1  buffer accepts an entry this cycle.
REQ-009 The block SHALL have port in_we  input  NPORT  per-port write enable.
REQ-010 The block SHALL have port in_waddr  input  NPORT*ADDR_W  per-port address, port k in bits [k*ADDR_W +: ADDR_W].
REQ-011 The block SHALL have port in_wdata  input  NPORT*DATA_W  per-port data, packed the same way as in_waddr.
REQ-012 The block SHALL have port stall_i  input  1  freeze: no push, no pop.
REQ-013 The block SHALL have port flush_i  input  1  discard all buffered entries.
REQ-014 The block SHALL have port out_valid  output  1  head entry presented to the register file.
REQ-015 The block SHALL have port out_ready  input  1  register file consumes the head entry.
REQ-016 The block SHALL have ports out_we, out_waddr and out_wdata  output  NPORT, NPORT*ADDR_W, NPORT*DATA_W  head entry contents.
REQ-017 The block SHALL have port fwd_raddr  input  ADDR_W  forwarding lookup address.
REQ-018 The block SHALL have port fwd_hit  output  1  a buffered write matches fwd_raddr.
REQ-019 The block SHALL have port fwd_data  output  DATA_W  forwarded data, zero when fwd_hit=0.
REQ-020 The block SHALL have port count_o  output  log2(DEPTH)+1  number of buffered entries.

Function
REQ-021 The buffer SHALL be a circular FIFO with read pointer, write pointer and count; the pointers wrap modulo DEPTH.
REQ-022 in_ready SHALL be 1 only when count_o<DEPTH, stall_i=0 and flush_i=0.
REQ-023 in_ready SHALL have no combinational path from out_ready; when the buffer is full, a push is refused even in a popping cycle.
REQ-024 A push SHALL occur when in_valid=1 and in_ready=1; the entry is visible at out_* no earlier than the next cycle (1-cycle minimum latency).
REQ-025 On push, a port with waddr=0 SHALL have its stored we forced to 0 (x0 is never written).
REQ-026 out_valid SHALL be 1 only when count_o!=0 and stall_i=0.
REQ-027 All out_* data/enable outputs SHALL be driven to zero while out_valid=0.
REQ-028 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-029 A simultaneous push and pop SHALL leave count_o unchanged and advance both pointers.
REQ-030 While stall_i=1, all state SHALL hold (same semantics as the existing hold behaviour of the writeback register).
REQ-031 flush_i=1 SHALL zero the count and both pointers at the next edge, and SHALL take priority over stall_i, push and pop in the same cycle.
REQ-032 Forwarding SHALL be combinational over the count_o valid entries only.
REQ-033 fwd_hit SHALL be 1 when any valid entry has a port with we=1 and waddr=fwd_raddr, with fwd_raddr!=0.
REQ-034 On multiple forwarding matches, the youngest entry SHALL win; within one entry, the highest port index SHALL win.
REQ-035 Forwarding SHALL ignore stall_i and flush_i in the current cycle.

Reset
REQ-036 On rst=0 at a clock edge, count_o, both pointers and all stored enables SHALL become 0.
REQ-037 While rst=0, out_valid SHALL be 0, in_ready SHALL be 0 and fwd_hit SHALL be 0; out_* and fwd_data are then zero by REQ-027 and REQ-019.
REQ-038 Reset SHALL take priority over flush_i and stall_i.
REQ-039 Stored data SHALL need no reset.

Structure
REQ-040 DATA_W and ADDR_W defaults SHALL come from the shared defines header (RegBus/RegAddrBus widths); no new package typedefs are needed.
REQ-041 One sub-module wb_fwd_match SHALL perform the combinational priority search of REQ-033 to REQ-034.
REQ-042 The FIFO storage and pointer logic SHALL remain in wb_stage_buf.

Verification
REQ-043 The bench SHALL check: rst=0 for 2 cycles then rst=1 -> count_o=0, out_valid=0, in_ready=1, fwd_hit=0.
REQ-044 The bench SHALL check: push {we=01, addr0=3, data0=0xA5}, out_ready=0 -> next cycle out_valid=1, out_waddr port0=3, out_wdata port0=0xA5, count_o=1.
REQ-045 The bench SHALL check: fill to DEPTH=2 with out_ready=1 on the full cycle -> in_ready=0 that cycle, one pop, count_o=1 next cycle.
REQ-046 The bench SHALL check: entries addr5=0x11 (older) and addr5=0x22 (younger), fwd_raddr=5 -> fwd_hit=1, fwd_data=0x22; fwd_raddr=0 -> fwd_hit=0.
REQ-047 The bench SHALL check: stall_i=1 with count_o=1, in_valid=1, out_ready=1 -> out_valid=0, in_ready=0, count_o unchanged for every stalled cycle.
REQ-048 The bench SHALL check: flush_i=1 together with stall_i=1, in_valid=1 and count_o=2 -> count_o=0 next cycle, out_valid=0, and no entry was pushed.
